// File: rtl/line_cache_multi.sv
// Read-only direct-mapped cache in front of the DDR3 Avalon read port.
// Each miss fills a whole line with one burst; hits answer the next cycle.
module line_cache_multi #(
    parameter int ADDR_W     = 29,
    parameter int DATA_W     = 64,
    parameter int LINE_WORDS = 8,
    parameter int LINES      = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ddram_addr_in,
    input  logic              ddram_rd_in,
    input  logic              flush_in,
    output logic              ready_out,
    output logic [DATA_W-1:0] ddram_readdata_out,
    output logic              ddram_valid_out,
    output logic [ADDR_W-1:0] ddram_addr_out,
    output logic [7:0]        ddram_burstcnt_out,
    output logic              ddram_rd_out,
    input  logic              ddram_waitrequest_in,
    input  logic              ddram_valid_in,
    input  logic [DATA_W-1:0] ddram_readdata_in
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int IDX_S = (IDX_W == 0) ? 1 : IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tags_q [LINES];
    logic [DATA_W-1:0] data_q [LINES][LINE_WORDS];

    logic [IDX_S-1:0]  idx_q, idx_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [TAG_W-1:0]  lineTag_q, lineTag_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic              flushPend_q, flushPend_d;
    logic              rdOut_q, rdOut_d;
    logic [ADDR_W-1:0] addrOut_q, addrOut_d;
    logic              validOut_q, validOut_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [TAG_W-1:0]  reqTag;
    logic [IDX_S-1:0]  reqIdx;
    logic [OFF_W-1:0]  reqOff;
    logic              hit;
    logic              lastBeat;

    assign reqTag = ddram_addr_in[ADDR_W-1:IDX_W+OFF_W];
    assign reqOff = ddram_addr_in[OFF_W-1:0];

    // With a single line there are no index bits, so every access maps to line 0.
    if (IDX_W > 0) begin : g_idx
        assign reqIdx = ddram_addr_in[IDX_W+OFF_W-1:OFF_W];
    end else begin : g_noidx
        assign reqIdx = '0;
    end

    // A flush in the same cycle as a read must force the read down the miss path.
    assign hit      = valid_q[reqIdx] && (tags_q[reqIdx] == reqTag) && !flush_in;
    assign lastBeat = (beat_q == OFF_W'(LINE_WORDS - 1));

    assign ready_out          = (state_q == IDLE);
    assign ddram_rd_out       = rdOut_q;
    assign ddram_addr_out     = addrOut_q;
    assign ddram_burstcnt_out = 8'(LINE_WORDS);
    assign ddram_valid_out    = validOut_q;
    assign ddram_readdata_out = rdata_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        idx_d       = idx_q;
        off_d       = off_q;
        lineTag_d   = lineTag_q;
        beat_d      = beat_q;
        flushPend_d = flushPend_q;
        rdOut_d     = rdOut_q;
        addrOut_d   = addrOut_q;
        validOut_d  = 1'b0;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (flush_in) valid_d = '0;
                if (ddram_rd_in) begin
                    if (hit) begin
                        validOut_d = 1'b1;
                        rdata_d    = data_q[reqIdx][reqOff];
                    end else begin
                        idx_d     = reqIdx;
                        off_d     = reqOff;
                        lineTag_d = reqTag;
                        beat_d    = '0;
                        addrOut_d = ddram_addr_in & ~ADDR_W'(LINE_WORDS - 1);
                        rdOut_d   = 1'b1;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (flush_in) flushPend_d = 1'b1;
                if (!ddram_waitrequest_in) begin
                    rdOut_d = 1'b0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (flush_in) flushPend_d = 1'b1;
                // The burst always runs to completion; a flush only decides whether the line is kept.
                if (ddram_valid_in) begin
                    beat_d = beat_q + 1'b1;
                    if (lastBeat) begin
                        if (flushPend_q || flush_in) valid_d = '0;
                        else valid_d[idx_q] = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                validOut_d  = 1'b1;
                rdata_d     = data_q[idx_q][off_q];
                flushPend_d = 1'b0;
                if (flush_in) valid_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            idx_q       <= '0;
            off_q       <= '0;
            lineTag_q   <= '0;
            beat_q      <= '0;
            flushPend_q <= 1'b0;
            rdOut_q     <= 1'b0;
            addrOut_q   <= '0;
            validOut_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            idx_q       <= idx_d;
            off_q       <= off_d;
            lineTag_q   <= lineTag_d;
            beat_q      <= beat_d;
            flushPend_q <= flushPend_d;
            rdOut_q     <= rdOut_d;
            addrOut_q   <= addrOut_d;
            validOut_q  <= validOut_d;
            rdata_q     <= rdata_d;
        end
    end

    // Line storage carries no reset; the valid bits alone decide whether its contents are used.
    always_ff @(posedge clock) begin
        if (!reset && state_q == FILL && ddram_valid_in) begin
            data_q[idx_q][beat_q] <= ddram_readdata_in;
            if (lastBeat) tags_q[idx_q] <= lineTag_q;
        end
    end

endmodule

// File: tb/tb_line_cache_multi.sv
// Scoreboard bench for line_cache_multi: a small Avalon DDR model answers bursts,
// expected read data is queued at request acceptance and compared as results return.
module tb_line_cache_multi;

    logic        clock = 1'b0;
    logic        reset;
    logic [28:0] ddram_addr_in;
    logic        ddram_rd_in;
    logic        flush_in;
    logic        ready_out;
    logic [63:0] ddram_readdata_out;
    logic        ddram_valid_out;
    logic [28:0] ddram_addr_out;
    logic [7:0]  ddram_burstcnt_out;
    logic        ddram_rd_out;
    logic        ddram_waitrequest_in;
    logic        ddram_valid_in;
    logic [63:0] ddram_readdata_in;

    int vectors    = 0;
    int miscompares = 0;

    logic [63:0] sbq [$];

    int          waitLeft   = 0;
    int          burstsIssued = 0;
    logic        active     = 1'b0;
    logic        gapMode    = 1'b0;
    logic [28:0] burstAddr  = '0;
    int          beatIdx    = 0;

    line_cache_multi dut (
        .clock                (clock),
        .reset                (reset),
        .ddram_addr_in        (ddram_addr_in),
        .ddram_rd_in          (ddram_rd_in),
        .flush_in             (flush_in),
        .ready_out            (ready_out),
        .ddram_readdata_out   (ddram_readdata_out),
        .ddram_valid_out      (ddram_valid_out),
        .ddram_addr_out       (ddram_addr_out),
        .ddram_burstcnt_out   (ddram_burstcnt_out),
        .ddram_rd_out         (ddram_rd_out),
        .ddram_waitrequest_in (ddram_waitrequest_in),
        .ddram_valid_in       (ddram_valid_in),
        .ddram_readdata_in    (ddram_readdata_in)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ddrData(input logic [28:0] a);
        logic [31:0] w;
        w = {3'b000, a};
        return {32'hC0DE_0000 ^ w, w * 32'h9E37_79B1 + 32'h0000_1234};
    endfunction

    // DDR model: a burst is taken at the edge where rd is high and waitrequest low
    always @(posedge clock) begin
        if (reset) begin
            active = 1'b0;
        end else if (ddram_rd_out && !ddram_waitrequest_in) begin
            burstsIssued++;
            burstAddr = ddram_addr_out;
            beatIdx   = 0;
            active    = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (ddram_rd_out && waitLeft > 0) begin
            ddram_waitrequest_in = 1'b1;
            waitLeft--;
        end else begin
            ddram_waitrequest_in = 1'b0;
        end
        if (active && !(gapMode && $urandom_range(0, 3) == 0)) begin
            ddram_valid_in    = 1'b1;
            ddram_readdata_in = ddrData(burstAddr + 29'(beatIdx));
            beatIdx++;
            if (beatIdx == 8) active = 1'b0;
        end else begin
            ddram_valid_in    = 1'b0;
            ddram_readdata_in = '0;
        end
    end

    // Result monitor: every valid_out pulse must match the oldest queued expectation
    always @(negedge clock) begin
        if (!reset && ddram_valid_out) begin
            vectors++;
            if (ddram_rd_out) begin
                miscompares++;
                $display("[TB] FAIL valid_rd_overlap: rd_out=%0b while valid_out=1, required 0", ddram_rd_out);
            end
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_result: got data %h, required no result", ddram_readdata_out);
            end else begin
                logic [63:0] exp;
                exp = sbq.pop_front();
                if (ddram_readdata_out !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL read_data: got %h, required %h", ddram_readdata_out, exp);
                end
            end
        end
    end

    task automatic issueRead(input logic [28:0] addr, input logic withFlush);
        int n = 0;
        ddram_addr_in = addr;
        ddram_rd_in   = 1'b1;
        flush_in      = withFlush;
        while (!ready_out && n < 100) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (!ready_out) begin
            miscompares++;
            $display("[TB] FAIL accept_timeout: ready_out=%0b, required 1", ready_out);
        end
        sbq.push_back(ddrData(addr));
        @(negedge clock);
        ddram_rd_in = 1'b0;
        flush_in    = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!(sbq.size() == 0 && ready_out && !active) && n < budget) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("[TB] FAIL done_timeout: %0d results outstanding, required 0", sbq.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ddram_addr_in = '0;
        ddram_rd_in = 1'b0;
        flush_in = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vectors += 6;
        if (ready_out !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b, required 1", ready_out); end
        if (ddram_rd_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd: got %b, required 0", ddram_rd_out); end
        if (ddram_valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b, required 0", ddram_valid_out); end
        if (ddram_addr_out !== 29'h0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h, required 0", ddram_addr_out); end
        if (ddram_burstcnt_out !== 8'd8) begin miscompares++; $display("[TB] FAIL reset_burstcnt: got %0d, required 8", ddram_burstcnt_out); end
        if (ddram_readdata_out !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h, required 0", ddram_readdata_out); end
    endtask

    task automatic test_miss_fill();
        int b0 = burstsIssued;
        int n = 0;
        int readyBad = 0;
        issueRead(29'h40, 1'b0);
        vectors += 4;
        if (ddram_rd_out !== 1'b1) begin miscompares++; $display("[TB] FAIL miss_rd: got %b, required 1", ddram_rd_out); end
        if (ddram_addr_out !== 29'h40) begin miscompares++; $display("[TB] FAIL miss_addr: got %h, required 40", ddram_addr_out); end
        if (ddram_burstcnt_out !== 8'd8) begin miscompares++; $display("[TB] FAIL miss_burstcnt: got %0d, required 8", ddram_burstcnt_out); end
        if (ready_out !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_ready_low: got %b, required 0", ready_out); end
        while (!ddram_valid_out && n < 60) begin
            if (ready_out) readyBad++;
            @(negedge clock);
            n++;
        end
        vectors += 2;
        if (readyBad != 0) begin miscompares++; $display("[TB] FAIL fill_ready: %0d busy cycles with ready=1, required 0", readyBad); end
        if (ready_out !== 1'b1) begin miscompares++; $display("[TB] FAIL resp_ready: got %b, required 1", ready_out); end
        waitDone(60);
        vectors++;
        if (burstsIssued - b0 != 1) begin miscompares++; $display("[TB] FAIL miss_bursts: got %0d, required 1", burstsIssued - b0); end
    endtask

    task automatic test_back_to_back();
        int b0 = burstsIssued;
        int missingPulse = 0;
        int notReady = 0;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0 && !ddram_valid_out) missingPulse++;
            if (i < 8) begin
                ddram_addr_in = 29'h40 + 29'(i);
                ddram_rd_in = 1'b1;
                if (!ready_out) notReady++;
                sbq.push_back(ddrData(29'h40 + 29'(i)));
            end else begin
                ddram_rd_in = 1'b0;
            end
            @(negedge clock);
        end
        waitDone(20);
        vectors += 3;
        if (missingPulse != 0) begin miscompares++; $display("[TB] FAIL hit_latency: %0d cycles without a pulse, required 0", missingPulse); end
        if (notReady != 0) begin miscompares++; $display("[TB] FAIL hit_ready: %0d not-ready cycles, required 0", notReady); end
        if (burstsIssued != b0) begin miscompares++; $display("[TB] FAIL hit_bursts: got %0d, required 0", burstsIssued - b0); end
    endtask

    task automatic test_eviction();
        int b0;
        gapMode = 1'b1;
        b0 = burstsIssued;
        issueRead(29'h68, 1'b0);
        waitDone(100);
        issueRead(29'h45, 1'b0);
        issueRead(29'h6A, 1'b0);
        waitDone(20);
        vectors++;
        if (burstsIssued - b0 != 1) begin miscompares++; $display("[TB] FAIL two_line_hits: got %0d bursts, required 1", burstsIssued - b0); end
        issueRead(29'h140, 1'b0);
        vectors++;
        if (ddram_addr_out !== 29'h140) begin miscompares++; $display("[TB] FAIL evict_addr: got %h, required 140", ddram_addr_out); end
        waitDone(100);
        issueRead(29'h41, 1'b0);
        waitDone(100);
        issueRead(29'h6A, 1'b0);
        waitDone(20);
        vectors++;
        if (burstsIssued - b0 != 3) begin miscompares++; $display("[TB] FAIL evict_bursts: got %0d bursts, required 3", burstsIssued - b0); end
        gapMode = 1'b0;
    endtask

    task automatic test_waitrequest();
        int b0 = burstsIssued;
        int held = 0;
        int addrBad = 0;
        waitLeft = 5;
        issueRead(29'h80, 1'b0);
        while (ddram_rd_out && held < 50) begin
            if (ddram_addr_out !== 29'h80) addrBad++;
            held++;
            @(negedge clock);
        end
        waitDone(60);
        vectors += 3;
        if (held != 6) begin miscompares++; $display("[TB] FAIL wait_hold: rd held %0d cycles, required 6", held); end
        if (addrBad != 0) begin miscompares++; $display("[TB] FAIL wait_addr: %0d unstable cycles, required 0", addrBad); end
        if (burstsIssued - b0 != 1) begin miscompares++; $display("[TB] FAIL wait_bursts: got %0d, required 1", burstsIssued - b0); end
    endtask

    task automatic test_flush_fill();
        int b0 = burstsIssued;
        int n = 0;
        issueRead(29'h43, 1'b0);
        while (ddram_rd_out && n < 50) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        flush_in = 1'b1;
        @(negedge clock);
        flush_in = 1'b0;
        waitDone(60);
        issueRead(29'h40, 1'b0);
        waitDone(60);
        issueRead(29'h6A, 1'b0);
        waitDone(60);
        vectors++;
        if (burstsIssued - b0 != 3) begin miscompares++; $display("[TB] FAIL flush_fill_bursts: got %0d, required 3", burstsIssued - b0); end
    endtask

    task automatic test_flush_read();
        int b0 = burstsIssued;
        issueRead(29'h40, 1'b1);
        vectors += 2;
        if (ddram_rd_out !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_rd: got %b, required 1", ddram_rd_out); end
        if (ddram_addr_out !== 29'h40) begin miscompares++; $display("[TB] FAIL flush_addr: got %h, required 40", ddram_addr_out); end
        waitDone(60);
        issueRead(29'h6A, 1'b0);
        waitDone(60);
        vectors++;
        if (burstsIssued - b0 != 2) begin miscompares++; $display("[TB] FAIL flush_read_bursts: got %0d, required 2", burstsIssued - b0); end
    endtask

    initial begin
        ddram_waitrequest_in = 1'b0;
        ddram_valid_in = 1'b0;
        ddram_readdata_in = '0;
        test_reset();
        test_miss_fill();
        test_back_to_back();
        test_eviction();
        test_waitrequest();
        test_flush_fill();
        test_flush_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
